instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/HALT control and the IF/ID register.
// The instruction memory is combinational, so fetch has zero added latency.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'd4095
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_r;
  logic [63:0] pc_r;
  logic        out_valid_r;
  logic [63:0] out_pc_r;
  logic [31:0] out_instr_r;
  logic [31:0] fetch_count_r;

  logic        fire_s;
  logic        slot_free_s;
  logic        end_of_program_s;
  logic [63:0] pc_plus3_s;
  logic [63:0] pc_plus4_s;
  logic [63:0] redirect_target_s;

  // Handshake qualifiers, fetch-bound test and next-PC arithmetic.
  always_comb begin
    fire_s            = out_valid_r && out_ready;
    slot_free_s       = !out_valid_r || out_ready;
    pc_plus3_s        = pc_r + 64'd3;
    pc_plus4_s        = pc_r + 64'd4;
    redirect_target_s = redirect_pc & ~64'd3;
    end_of_program_s  = (imem_instr == 32'h0) || (pc_plus3_s >= MEM_SIZE);
  end

  // Main state machine: reset, then redirect, then RUN/HALT sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r          <= RESET_PC;
      state_r       <= RUN;
      out_valid_r   <= 1'b0;
      out_pc_r      <= 64'h0;
      out_instr_r   <= 32'h0;
      fetch_count_r <= 32'h0;
    end else if (redirect_valid) begin
      // A held instruction is dropped, so a coincident handshake is not counted.
      pc_r        <= redirect_target_s;
      out_valid_r <= 1'b0;
      state_r     <= RUN;
    end else begin
      if (fire_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      case (state_r)
        RUN: begin
          if (slot_free_s) begin
            if (!end_of_program_s) begin
              out_pc_r    <= pc_r;
              out_instr_r <= imem_instr;
              out_valid_r <= 1'b1;
              pc_r        <= pc_plus4_s;
            end else begin
              out_valid_r <= 1'b0;
              state_r     <= HALT;
            end
          end
        end
        HALT: begin
          if (fire_s) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: park safely until a redirect or reset.
          out_valid_r <= 1'b0;
          state_r     <= HALT;
        end
      endcase
    end
  end

  assign imem_addr   = pc_r;
  assign out_valid   = out_valid_r;
  assign out_pc      = out_pc_r;
  assign out_instr   = out_instr_r;
  assign halted      = (state_r == HALT);
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random redirects, resets and
// back-pressure, with a stream scoreboard popped by an independent monitor.
module tb_instruction_fetch;

  localparam logic [63:0] RST_PC    = 64'h0;
  localparam logic [63:0] MEM_BYTES = 64'd255;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];

  int          total = 0;
  int          bad   = 0;
  int          exp_count = 0;
  bit          chk_en = 0;
  logic [63:0] exp_halt_pc;
  logic [63:0] q_pc[$];
  logic [31:0] q_instr[$];

  instruction_fetch #(
    .RESET_PC (RST_PC),
    .MEM_SIZE (MEM_BYTES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 64'd256) ? mem[imem_addr[7:2]] : 32'h0;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a < 64'd256) return mem[a[7:2]];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The program the fetcher must hand to decode after a (re)start at start_pc.
  task automatic restart_stream(input logic [63:0] start_pc);
    logic [63:0] a;
    q_pc.delete();
    q_instr.delete();
    a = start_pc;
    while (word_at(a) != 32'h0 && (a + 64'd3) < MEM_BYTES) begin
      q_pc.push_back(a);
      q_instr.push_back(word_at(a));
      a = a + 64'd4;
    end
    exp_halt_pc = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (halted === 1'b1 && out_valid === 1'b0) done = 1'b1;
      else tick();
    end
    check("halt_reached", {63'h0, done}, 64'd1);
  endtask

  task automatic rand_fill(input int zero_odds);
    for (int i = 0; i < 64; i++)
      mem[i] = (($urandom % zero_odds) == 0) ? 32'h0 : ($urandom | 32'h1);
  endtask

  // Monitor: counts handshakes, pops the expected stream, checks idle-in-HALT state.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      exp_count = 0;
      chk_en    = 1'b1;
    end else if (chk_en) begin
      check("fetch_count", {32'h0, fetch_count}, exp_count);
      if (redirect_valid !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        check("fire_allowed", {63'h0, q_pc.size() > 0}, 64'd1);
        if (q_pc.size() > 0) begin
          check("stream_pc", out_pc, q_pc.pop_front());
          check("stream_instr", {32'h0, out_instr}, {32'h0, q_instr.pop_front()});
        end
        exp_count++;
      end else if (redirect_valid !== 1'b1 && halted === 1'b1 && out_valid === 1'b0) begin
        check("halt_stream_empty", q_pc.size(), 64'd0);
        check("halt_pc", imem_addr, exp_halt_pc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Streaming: three words, then a zero word.
    mem[0] = 32'h1111_0013;
    mem[1] = 32'h2222_0013;
    mem[2] = 32'h3333_0013;
    restart_stream(RST_PC);
    tick();
    tick();
    check("rst_valid", {63'h0, out_valid}, 64'd0);
    check("rst_halted", {63'h0, halted}, 64'd0);
    check("rst_pc", imem_addr, RST_PC);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_out_instr", {32'h0, out_instr}, 64'h0);
    check("rst_count", {32'h0, fetch_count}, 64'd0);
    reset = 1'b1;
    tick();
    check("s1_pc0", out_pc, 64'h0);
    check("s1_instr0", {32'h0, out_instr}, 64'h1111_0013);
    check("s1_valid0", {63'h0, out_valid}, 64'd1);
    tick();
    check("s1_pc4", out_pc, 64'h4);
    tick();
    check("s1_pc8", out_pc, 64'h8);
    tick();
    check("s1_halted", {63'h0, halted}, 64'd1);
    check("s1_valid", {63'h0, out_valid}, 64'd0);
    check("s1_count", {32'h0, fetch_count}, 64'd3);
    check("s1_final_pc", imem_addr, 64'd12);

    // Stall: hold for four cycles after the first load.
    for (int i = 0; i < 6; i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b0;
    out_ready = 1'b0;
    restart_stream(RST_PC);
    tick();
    check("s2_rst_halted", {63'h0, halted}, 64'd0);
    reset = 1'b1;
    tick();
    check("s2_first_pc", out_pc, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s2_hold_out_pc", out_pc, 64'h0);
      check("s2_hold_pc", imem_addr, 64'h4);
      check("s2_hold_valid", {63'h0, out_valid}, 64'd1);
      check("s2_hold_count", {32'h0, fetch_count}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("s2_rel_count", {32'h0, fetch_count}, 64'd1);
    check("s2_rel_pc", out_pc, 64'h4);
    wait_halt(50);
    check("s2_end_count", {32'h0, fetch_count}, 64'd6);
    check("s2_end_pc", imem_addr, 64'd24);

    // Redirect while a valid instruction is being accepted.
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 10; i++) mem[i] = 32'hB000_0000 + 32'(i);
    for (int i = 16; i < 20; i++) mem[i] = 32'hC000_0000 + 32'(i);
    reset = 1'b0;
    restart_stream(RST_PC);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("s3_pre_pc", out_pc, 64'h4);
    check("s3_pre_count", {32'h0, fetch_count}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    restart_stream(64'h40);
    tick();
    check("s3_flush_valid", {63'h0, out_valid}, 64'd0);
    check("s3_flush_count", {32'h0, fetch_count}, 64'd1);
    check("s3_new_pc", imem_addr, 64'h40);
    redirect_valid = 1'b0;
    tick();
    check("s3_target_out_pc", out_pc, 64'h40);
    check("s3_target_instr", {32'h0, out_instr}, 64'hC000_0010);
    wait_halt(50);
    check("s3_end_pc", imem_addr, 64'h50);
    check("s3_end_count", {32'h0, fetch_count}, 64'd5);

    // Misaligned redirect wakes the fetcher from HALT.
    mem[10] = 32'hD000_000A;
    mem[11] = 32'hD000_000B;
    redirect_valid = 1'b1;
    redirect_pc = 64'h2A;
    restart_stream(64'h28);
    tick();
    check("s4_halted", {63'h0, halted}, 64'd0);
    check("s4_pc", imem_addr, 64'h28);
    redirect_valid = 1'b0;
    tick();
    check("s4_out_pc", out_pc, 64'h28);
    wait_halt(50);
    check("s4_end_pc", imem_addr, 64'h30);
    check("s4_end_count", {32'h0, fetch_count}, 64'd7);

    // Memory bound: every word nonzero, the last word's 3 extra bytes cross the bound.
    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
    redirect_valid = 1'b1;
    redirect_pc = 64'hF0;
    restart_stream(64'hF0);
    tick();
    redirect_valid = 1'b0;
    tick();
    check("s5_pc_f0", out_pc, 64'hF0);
    tick();
    check("s5_pc_f4", out_pc, 64'hF4);
    tick();
    check("s5_pc_f8", out_pc, 64'hF8);
    tick();
    check("s5_halted", {63'h0, halted}, 64'd1);
    check("s5_bound_pc", imem_addr, 64'hFC);
    check("s5_count", {32'h0, fetch_count}, 64'd10);

    // Reset in the middle of a stall with pc = 8.
    reset = 1'b0;
    restart_stream(RST_PC);
    tick();
    reset = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    check("s6_stall_pc", imem_addr, 64'h8);
    check("s6_stall_out_pc", out_pc, 64'h4);
    reset = 1'b0;
    restart_stream(RST_PC);
    tick();
    check("s6_rst_pc", imem_addr, RST_PC);
    check("s6_rst_valid", {63'h0, out_valid}, 64'd0);
    check("s6_rst_count", {32'h0, fetch_count}, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("s6_first_out_pc", out_pc, RST_PC);
    check("s6_first_valid", {63'h0, out_valid}, 64'd1);

    // Random back-pressure, redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset = 1'b1;
      redirect_valid = 1'b0;
      out_ready = (($urandom % 4) != 0);
      r = int'($urandom % 100);
      if (r < 3) begin
        redirect_valid = 1'b1;
        redirect_pc = 64'($urandom_range(0, 255));
        restart_stream(redirect_pc & ~64'd3);
      end else if (r == 3) begin
        rand_fill(16);
        reset = 1'b0;
        restart_stream(RST_PC);
      end
      tick();
    end
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    wait_halt(400);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
